mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 32x16 program/data memory between the CPU core (cpu_*) and a host
//  loader/debug port (host_*). Each access is one request/done transaction; the arbiter owns
//  the memory-side address/write-data/write-enable registers. Sits between cpu_core, host and RAM.
// PARAMETERS
//  ADDR_W   5   memory address width (32 words)
//  DATA_W   16  memory word width
// PORTS
//  clock           in   1       system clock, all state updates on rising edge
//  reset           in   1       synchronous, active-high reset
//  cpu_req         in   1       CPU access request, held until cpu_done
//  cpu_we          in   1       1=write, 0=read
//  cpu_addr        in   ADDR_W  CPU word address
//  cpu_wdata       in   DATA_W  CPU write data
//  cpu_done        out  1       1-cycle pulse: CPU access complete
//  cpu_rdata       out  DATA_W  CPU read data, valid with cpu_done, held until next cpu read done
//  host_req/_we/_addr/_wdata  in   1/1/ADDR_W/DATA_W  host port, same rules as cpu_*
//  host_done       out  1       1-cycle pulse: host access complete
//  host_rdata      out  DATA_W  host read data, same rules as cpu_rdata
//  mem_addr        out  ADDR_W  registered RAM address
//  mem_write_data  out  DATA_W  registered RAM write data
//  mem_write       out  1       registered RAM write enable
//  mem_read_data   in   DATA_W  RAM combinational read of mem_addr
//  busy            out  1       1 when state != IDLE
//  owner_host      out  1       1 when current/last grant went to host
// BEHAVIOUR
//  Reset (sync): state=IDLE; mem_addr=0, mem_write_data=0, mem_write=0; cpu_done=host_done=0;
//   cpu_rdata=host_rdata=0; busy=0; owner_host=0. Reset mid-access drops it: no done, no write.
//  FSM IDLE -> ACCESS -> RESP -> IDLE; 3 cycles per access, req-sample to done = 2 cycles.
//  IDLE (cycle 0): if any req, pick winner; register addr/wdata, mem_write<=winner_we,
//   owner_host<=winner; ->ACCESS. No req: stay, mem_write stays 0.
//  ACCESS (cycle 1): RAM write occurs at end of this cycle if mem_write; read data sampled from
//   mem_read_data into winner's rdata; mem_write<=0; winner's done<=1; ->RESP.
//  RESP (cycle 2): done high exactly this cycle; requests ignored; done<=0; ->IDLE.
//  Requester must change/drop req by the edge ending its done cycle; req/we/addr/wdata are
//   captured at grant, later changes ignored. Loser's req stays pending, served next IDLE.
//  rdata updates only on a read completion for that port; writes leave rdata unchanged.
//  Tie (both req in IDLE): host wins (fixed priority) unless MEM_ARB_RR_EN.
//  Addresses wrap naturally within ADDR_W; no range check.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin on ties -- winner is the port not granted last time
//   (last-owner flop reset to host, so CPU wins first tie after reset). Guarantees no starvation.
//  Undefined: fixed priority, host always wins ties; CPU can starve under continuous host req.
// STRUCTURE
//  mem_arb_pkg (include): state encodings IDLE/ACCESS/RESP, owner encoding (CPU=0, HOST=1),
//   default ADDR_W/DATA_W.
//  One sub-module: mem_arb_grant -- winner select from cpu_req/host_req + last-owner flop (RR).
// TESTING
//  1. reset, cpu read addr 3 (RAM[3]=16'hA5A5) -> cpu_done 2 cycles after req seen, cpu_rdata=A5A5.
//  2. host write addr 7 data 16'h1234, then cpu read 7 -> mem_write high 1 cycle; cpu_rdata=1234.
//  3. cpu and host req same cycle, fixed prio -> host_done first, cpu_done 3 cycles later.
//  4. MEM_ARB_RR_EN, both req held 4 transactions -> grants CPU,HOST,CPU,HOST.
//  5. reset asserted in ACCESS of a write to addr 2 -> RAM[2] unchanged, no done, all outputs 0.
//  6. host write addr 31 then addr 0 back-to-back -> both writes land, host_rdata unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/host memory port arbiter: FSM states, owner encoding, default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select between CPU and host requests. Build with MEM_ARB_RR_EN for round-robin
// tie-breaking; otherwise the host always wins a tie.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   i_cpu_req,
  input  logic   i_host_req,
  input  logic   i_grant_en,
  output owner_t o_winner
);

  owner_t w_tie_pick;

`ifdef MEM_ARB_RR_EN
  owner_t r_last_owner;

  // Last owner starts as host so the first tie after reset goes to the CPU.
  always_ff @(posedge clock) begin
    if (reset)
      r_last_owner <= OWN_HOST;
    else if (i_grant_en)
      r_last_owner <= o_winner;
  end

  assign w_tie_pick = (r_last_owner == OWN_HOST) ? OWN_CPU : OWN_HOST;
`else
  logic w_unused_ok;

  assign w_tie_pick  = OWN_HOST;
  assign w_unused_ok = ^{clock, reset, i_grant_en};
`endif

  always_comb begin
    o_winner = w_tie_pick;
    if (i_host_req && !i_cpu_req)
      o_winner = OWN_HOST;
    else if (i_cpu_req && !i_host_req)
      o_winner = OWN_CPU;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between CPU and host: IDLE -> ACCESS -> RESP per access.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking in mem_arb_grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_done,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              owner_host
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_grant_en;
  owner_t            w_winner;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_write;
  logic              r_cpu_done;
  logic              r_host_done;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  mem_arb_grant u_grant (
    .clock      (clock),
    .reset      (reset),
    .i_cpu_req  (cpu_req),
    .i_host_req (host_req),
    .i_grant_en (w_grant_en),
    .o_winner   (w_winner)
  );

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_en = cpu_req || host_req;
        if (w_grant_en)
          w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory-side registers, done pulses and per-port read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner      <= OWN_CPU;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_write  <= 1'b0;
      r_cpu_done   <= 1'b0;
      r_host_done  <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_owner <= w_winner;
            if (w_winner == OWN_HOST) begin
              r_mem_addr  <= host_addr;
              r_mem_wdata <= host_wdata;
              r_mem_write <= host_we;
            end else begin
              r_mem_addr  <= cpu_addr;
              r_mem_wdata <= cpu_wdata;
              r_mem_write <= cpu_we;
            end
          end
        end
        ST_ACCESS: begin
          r_mem_write <= 1'b0;
          if (r_owner == OWN_HOST) begin
            r_host_done <= 1'b1;
            if (!r_mem_write)
              r_host_rdata <= mem_read_data;
          end else begin
            r_cpu_done <= 1'b1;
            if (!r_mem_write)
              r_cpu_rdata <= mem_read_data;
          end
        end
        ST_RESP: begin
          r_cpu_done  <= 1'b0;
          r_host_done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Write enable is masked by reset so an access interrupted in ACCESS never lands in RAM.
  assign mem_write      = r_mem_write & ~reset;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign cpu_done       = r_cpu_done;
  assign host_done      = r_host_done;
  assign cpu_rdata      = r_cpu_rdata;
  assign host_rdata     = r_host_rdata;
  assign busy           = (r_state != ST_IDLE);
  assign owner_host     = (r_owner == OWN_HOST);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [4:0]  cpu_addr, host_addr;
  logic [15:0] cpu_wdata, host_wdata;
  logic        cpu_done, host_done, mem_write, busy, owner_host;
  logic [15:0] cpu_rdata, host_rdata, mem_write_data, mem_read_data;
  logic [4:0]  mem_addr;

  logic [15:0] ram [32];
  logic [15:0] ref_mem [32];
  logic [15:0] m_cpu_rdata, m_host_rdata;
  bit          m_last_host;
  int          n_vec = 0;
  int          n_err = 0;

  mem_port_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_done       (cpu_done),
    .cpu_rdata      (cpu_rdata),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_done      (host_done),
    .host_rdata     (host_rdata),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .busy           (busy),
    .owner_host     (owner_host)
  );

  always #5 clock = ~clock;

  assign mem_read_data = ram[mem_addr];
  always @(posedge clock) if (mem_write) ram[mem_addr] <= mem_write_data;

  function automatic logic [4:0] rnd5();
    logic [31:0] r;
    r = $urandom;
    return r[4:0];
  endfunction

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_host  = 1'b1;
    m_cpu_rdata  = '0;
    m_host_rdata = '0;
  endtask

  // One or two concurrent requests, started from IDLE at a negedge; runs 6 cycles.
  task automatic txn(input bit creq, input bit cwe, input logic [4:0] caddr, input logic [15:0] cwd,
                     input bit hreq, input bit hwe, input logic [4:0] haddr, input logic [15:0] hwd);
    int          cd, hd;
    bit          first_host;
    logic [15:0] cval, hval;
    cd = 99; hd = 99; cval = '0; hval = '0;
    if (creq && hreq) first_host = RR ? !m_last_host : 1'b1;
    else              first_host = hreq;
    if (first_host) begin
      hd = 2;
      if (hwe) ref_mem[haddr] = hwd; else hval = ref_mem[haddr];
      m_last_host = 1'b1;
      if (creq) begin
        cd = 5;
        if (cwe) ref_mem[caddr] = cwd; else cval = ref_mem[caddr];
        m_last_host = 1'b0;
      end
    end else begin
      cd = 2;
      if (cwe) ref_mem[caddr] = cwd; else cval = ref_mem[caddr];
      m_last_host = 1'b0;
      if (hreq) begin
        hd = 5;
        if (hwe) ref_mem[haddr] = hwd; else hval = ref_mem[haddr];
        m_last_host = 1'b1;
      end
    end
    cpu_req = creq;  cpu_we = cwe;  cpu_addr = caddr;  cpu_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock);
      @(negedge clock);
      chk("cpu_done", 16'(cpu_done), 16'(c == cd));
      chk("host_done", 16'(host_done), 16'(c == hd));
      chk("busy", 16'(busy), 16'((c == cd - 1) || (c == cd) || (c == hd - 1) || (c == hd)));
      chk("mem_write", 16'(mem_write), 16'(((c == cd - 1) && cwe) || ((c == hd - 1) && hwe)));
      if (c == cd - 1) begin
        chk("cpu_grant_addr", 16'(mem_addr), 16'(caddr));
        chk("cpu_grant_owner", 16'(owner_host), 16'(0));
        if (cwe) chk("cpu_grant_wdata", mem_write_data, cwd);
        cpu_we = $urandom_range(1, 0) != 0; cpu_addr = rnd5(); cpu_wdata = rnd16();
      end
      if (c == hd - 1) begin
        chk("host_grant_addr", 16'(mem_addr), 16'(haddr));
        chk("host_grant_owner", 16'(owner_host), 16'(1));
        if (hwe) chk("host_grant_wdata", mem_write_data, hwd);
        host_we = $urandom_range(1, 0) != 0; host_addr = rnd5(); host_wdata = rnd16();
      end
      if (c == cd && !cwe) m_cpu_rdata = cval;
      if (c == hd && !hwe) m_host_rdata = hval;
      if (c == cd) cpu_req = 1'b0;
      if (c == hd) host_req = 1'b0;
      chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
      chk("host_rdata", host_rdata, m_host_rdata);
    end
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = rnd16();
      if (i == 3) ref_mem[i] = 16'hA5A5;
      if (i == 2) ref_mem[i] = 16'h0BAD;
      ram[i] <= ref_mem[i];
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cpu_done", 16'(cpu_done), 16'(0));
    chk("rst_host_done", 16'(host_done), 16'(0));
    chk("rst_busy", 16'(busy), 16'(0));
    chk("rst_owner", 16'(owner_host), 16'(0));
    chk("rst_mem_addr", 16'(mem_addr), 16'(0));
    chk("rst_mem_wdata", mem_write_data, 16'h0);
    chk("rst_mem_write", 16'(mem_write), 16'(0));
    chk("rst_cpu_rdata", cpu_rdata, 16'h0);
    chk("rst_host_rdata", host_rdata, 16'h0);
    reset = 1'b0;
    model_reset();

    // CPU read of a preloaded word
    txn(1'b1, 1'b0, 5'd3, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    chk("t1_cpu_rdata", cpu_rdata, 16'hA5A5);

    // Host write then CPU read-back
    txn(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b1, 5'd7, 16'h1234);
    txn(1'b1, 1'b0, 5'd7, 16'h0, 1'b0, 1'b0, 5'd0, 16'h0);
    chk("t2_cpu_rdata", cpu_rdata, 16'h1234);

    // Simultaneous requests, then held ties for four grants
    txn(1'b1, 1'b0, 5'd3, 16'h0, 1'b1, 1'b0, 5'd7, 16'h0);
    txn(1'b1, 1'b1, 5'd9, 16'hC0DE, 1'b1, 1'b0, 5'd9, 16'h0);
    txn(1'b1, 1'b0, 5'd9, 16'h0, 1'b1, 1'b1, 5'd10, 16'h7777);

    // Back-to-back host writes at both ends of the address range
    txn(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b1, 5'd31, 16'hAAAA);
    txn(1'b0, 1'b0, 5'd0, 16'h0, 1'b1, 1'b1, 5'd0, 16'h5555);
    chk("t6_ram31", ram[31], 16'hAAAA);
    chk("t6_ram0", ram[0], 16'h5555);

    for (int n = 0; n < 60; n++) begin
      bit cr, hr;
      cr = $urandom_range(1, 0) != 0;
      hr = $urandom_range(1, 0) != 0;
      if (!cr && !hr) cr = 1'b1;
      txn(cr, $urandom_range(1, 0) != 0, rnd5(), rnd16(), hr, $urandom_range(1, 0) != 0, rnd5(), rnd16());
    end

    // Reset while a CPU write to address 2 is in ACCESS
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd2; cpu_wdata = 16'hBEEF;
    @(posedge clock);
    @(negedge clock);
    chk("t5_access_write", 16'(mem_write), 16'(1));
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    chk("t5_write_masked", 16'(mem_write), 16'(0));
    @(posedge clock);
    @(negedge clock);
    chk("t5_ram2", ram[2], ref_mem[2]);
    chk("t5_cpu_done", 16'(cpu_done), 16'(0));
    chk("t5_busy", 16'(busy), 16'(0));
    chk("t5_mem_write", 16'(mem_write), 16'(0));
    chk("t5_mem_addr", 16'(mem_addr), 16'(0));
    chk("t5_cpu_rdata", cpu_rdata, 16'h0);
    chk("t5_host_rdata", host_rdata, 16'h0);
    chk("t5_owner", 16'(owner_host), 16'(0));
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      chk("t5_no_done", 16'(cpu_done), 16'(0));
    end
    txn(1'b1, 1'b0, 5'd2, 16'h0, 1'b1, 1'b0, 5'd3, 16'h0);

    for (int i = 0; i < 32; i++) chk("final_ram", ram[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
